// File: rtl/eth_tx_pkg.sv
// Shared types and defaults for the 10BASE-T transmit scheduler.
// One clk cycle is one bit time (100 ns at 10 MHz).
package eth_tx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_OFF    = 3'd0;
    localparam state_t ST_WAIT   = 3'd1;
    localparam state_t ST_NLP    = 3'd2;
    localparam state_t ST_FRAME  = 3'd3;
    localparam state_t ST_TP_IDL = 3'd4;
    localparam state_t ST_IPG    = 3'd5;
    localparam state_t ST_JABBER = 3'd6;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_OFF   = 2'b00;
    localparam sel_t SEL_NLP   = 2'b01;
    localparam sel_t SEL_FRAME = 2'b10;
    localparam sel_t SEL_IDL   = 2'b11;

    localparam int unsigned DEF_NLP_PERIOD    = 160000;
    localparam int unsigned DEF_NLP_WIDTH     = 1;
    localparam int unsigned DEF_IDL_CYCLES    = 3;
    localparam int unsigned DEF_IPG_CYCLES    = 96;
    localparam int unsigned DEF_START_TO      = 16;
    localparam int unsigned DEF_JABBER_CYCLES = 200000;
    localparam int unsigned DEF_UNJAB_CYCLES  = 5000;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/eth_tx_sched_if.sv
// Scheduler-facing bundle: MAC request/grant, frame engine activity and line mux control.
// frame_req is a level the MAC holds until frame_gnt pulses for one cycle; there is no back-pressure on the grant.
interface eth_tx_sched_if;
    import eth_tx_pkg::*;

    logic link_en;
    logic frame_req;
    logic frame_gnt;
    logic frame_active;
    logic nlp_go;
    sel_t sel;
    logic busy;
    logic jabber;

    modport master (
        input  link_en, frame_req, frame_active,
        output frame_gnt, nlp_go, sel, busy, jabber
    );

    modport slave (
        output link_en, frame_req, frame_active,
        input  frame_gnt, nlp_go, sel, busy, jabber
    );

endinterface

// File: rtl/eth_nlp_timer.sv
// Link-pulse interval timer: counts line-silence cycles and flags when the next NLP is due.
module eth_nlp_timer #(
    parameter int unsigned PERIOD = 160000,
    parameter int unsigned W      = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         count_i,
    input  logic         clear_i,
    input  logic         hold_i,
    output logic         due_o,
    output logic [W-1:0] tmr_o
);

    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] tmr_q;
    logic [W-1:0] tmr_d;

    assign due_o = (tmr_q == LAST);
    assign tmr_o = tmr_q;

    // Holding at LAST keeps an expiry that lands while the line is busy pending until it can be serviced.
    always_comb begin
        tmr_d = tmr_q;
        if (clear_i) begin
            tmr_d = '0;
        end else if (count_i && !(hold_i && due_o)) begin
            tmr_d = tmr_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

endmodule

// File: rtl/eth_tx_sched.sv
// 10BASE-T transmit scheduler: chooses the line source (silence, NLP, frame, TP_IDL),
// grants frame starts, enforces TP_IDL and IPG, and applies jabber protection.
module eth_tx_sched
    import eth_tx_pkg::*;
#(
    parameter int unsigned NLP_PERIOD    = DEF_NLP_PERIOD,
    parameter int unsigned NLP_WIDTH     = DEF_NLP_WIDTH,
    parameter int unsigned IDL_CYCLES    = DEF_IDL_CYCLES,
    parameter int unsigned IPG_CYCLES    = DEF_IPG_CYCLES,
    parameter int unsigned START_TO      = DEF_START_TO,
    parameter int unsigned JABBER_CYCLES = DEF_JABBER_CYCLES,
    parameter int unsigned UNJAB_CYCLES  = DEF_UNJAB_CYCLES,
    localparam int unsigned CW = $clog2(max2(max2(max2(NLP_PERIOD, NLP_WIDTH),
                                                  max2(IDL_CYCLES, IPG_CYCLES)),
                                             max2(max2(START_TO, JABBER_CYCLES),
                                                  UNJAB_CYCLES))) + 1
) (
    input  logic                clk,
    input  logic                rst,
    eth_tx_sched_if.master      bus,
    output state_t              state_o,
    output logic [CW-1:0]       nlp_tmr_o
);

    localparam logic [CW-1:0] NLPW_LAST  = CW'(NLP_WIDTH - 1);
    localparam logic [CW-1:0] IDL_LAST   = CW'(IDL_CYCLES - 1);
    localparam logic [CW-1:0] IPG_LAST   = CW'(IPG_CYCLES - 1);
    localparam logic [CW-1:0] START_LAST = CW'(START_TO - 1);
    localparam logic [CW-1:0] JAB_LAST   = CW'(JABBER_CYCLES - 1);
    localparam logic [CW-1:0] UNJAB_LAST = CW'(UNJAB_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          seen_q, seen_d;
    logic          gnt_q, gnt_d;
    logic          go_q, go_d;
    logic [CW-1:0] run_len;
    logic          nlp_due;
    logic          quiet_q, quiet_d;
    logic          tmr_count;
    sel_t          sel;

    // Once frame_active has been seen it stays high until FRAME is left, so cnt doubles as its run length.
    assign run_len = seen_q ? cnt_q : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        seen_d  = 1'b0;
        case (state_q)
            ST_OFF: begin
                cnt_d = '0;
                if (bus.link_en) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = '0;
                if (bus.frame_req)  state_d = ST_FRAME;
                else if (nlp_due)   state_d = ST_NLP;
            end
            ST_NLP: begin
                if (cnt_q == NLPW_LAST) state_d = ST_WAIT;
            end
            ST_FRAME: begin
                seen_d = seen_q | bus.frame_active;
                if (bus.frame_active && !seen_q) cnt_d = CW'(1);
                if (seen_q && !bus.frame_active) begin
                    state_d = ST_TP_IDL;
                end else if (!seen_q && !bus.frame_active && cnt_q == START_LAST) begin
                    state_d = ST_IPG;
                end else if (bus.frame_active && run_len == JAB_LAST) begin
                    state_d = ST_JABBER;
                end
            end
            ST_TP_IDL: begin
                if (cnt_q == IDL_LAST) state_d = ST_IPG;
            end
            ST_IPG: begin
                if (cnt_q == IPG_LAST) state_d = ST_WAIT;
            end
            ST_JABBER: begin
                if (bus.frame_active)          cnt_d = '0;
                else if (cnt_q == UNJAB_LAST)  state_d = ST_WAIT;
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
        if (!bus.link_en && state_q != ST_JABBER) state_d = ST_OFF;
        if (state_d != state_q) begin
            cnt_d  = '0;
            seen_d = 1'b0;
        end
    end

    assign gnt_d = (state_q == ST_WAIT) && (state_d == ST_FRAME);
    assign go_d  = (state_q == ST_WAIT) && (state_d == ST_NLP);

    // The NLP interval runs only across quiet line states and carries over from IPG into WAIT.
    assign quiet_q   = (state_q == ST_WAIT) || (state_q == ST_IPG);
    assign quiet_d   = (state_d == ST_WAIT) || (state_d == ST_IPG);
    assign tmr_count = quiet_q && quiet_d;

    eth_nlp_timer #(
        .PERIOD (NLP_PERIOD),
        .W      (CW)
    ) u_nlp_timer (
        .clk     (clk),
        .rst     (rst),
        .count_i (tmr_count),
        .clear_i (!tmr_count),
        .hold_i  (state_q == ST_IPG),
        .due_o   (nlp_due),
        .tmr_o   (nlp_tmr_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
            gnt_q   <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
            gnt_q   <= gnt_d;
            go_q    <= go_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_NLP:    sel = SEL_NLP;
            ST_FRAME:  sel = SEL_FRAME;
            ST_TP_IDL: sel = SEL_IDL;
            default:   sel = SEL_OFF;
        endcase
    end

    assign bus.sel       = sel;
    assign bus.frame_gnt = gnt_q;
    assign bus.nlp_go    = go_q;
    assign bus.busy      = (state_q != ST_OFF) && (state_q != ST_WAIT);
    assign bus.jabber    = (state_q == ST_JABBER);
    assign state_o       = state_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Self-checking bench for eth_tx_sched with shortened timing constants.
module tb_eth_tx_sched;
    import eth_tx_pkg::*;

    localparam int unsigned P_NLP   = 50;
    localparam int unsigned P_NLPW  = 1;
    localparam int unsigned P_IDL   = 3;
    localparam int unsigned P_IPG   = 8;
    localparam int unsigned P_START = 4;
    localparam int unsigned P_JAB   = 30;
    localparam int unsigned P_UNJAB = 10;
    localparam int unsigned TW      = $clog2(P_NLP) + 1;
    localparam int          FLEN    = 20;

    // Scoreboard vector: {busy, jabber, frame_gnt, nlp_go, sel}
    localparam logic [5:0] E_WAIT = 6'b000000;
    localparam logic [5:0] E_NLP  = 6'b100101;
    localparam logic [5:0] E_GNT  = 6'b101010;
    localparam logic [5:0] E_FRM  = 6'b100010;
    localparam logic [5:0] E_IDL  = 6'b100011;
    localparam logic [5:0] E_IPG  = 6'b100000;
    localparam logic [5:0] E_JAB  = 6'b110000;

    logic          clk;
    logic          rst;
    state_t        state;
    logic [TW-1:0] nlp_tmr;
    logic [5:0]    exp_q[$];
    int            n_checks;
    int            n_fail;

    eth_tx_sched_if bus();

    eth_tx_sched #(
        .NLP_PERIOD    (P_NLP),
        .NLP_WIDTH     (P_NLPW),
        .IDL_CYCLES    (P_IDL),
        .IPG_CYCLES    (P_IPG),
        .START_TO      (P_START),
        .JABBER_CYCLES (P_JAB),
        .UNJAB_CYCLES  (P_UNJAB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_o   (state),
        .nlp_tmr_o (nlp_tmr)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drivers: inputs change 1 time unit after the rising edge, outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int n, input logic [5:0] v);
        repeat (n) exp_q.push_back(v);
    endtask

    function automatic logic [5:0] obs_vec();
        return {bus.busy, bus.jabber, bus.frame_gnt, bus.nlp_go, bus.sel};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.link_en = 1'b0;
        bus.frame_req = 1'b0;
        bus.frame_active = 1'b0;
        tick();
        tick();
        n_checks++;
        if (state !== ST_OFF) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state, ST_OFF); end
        n_checks++;
        if (obs_vec() !== E_WAIT) begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs_vec(), E_WAIT); end
        n_checks++;
        if (nlp_tmr !== '0) begin n_fail++; $display("FAIL reset_nlp_tmr: got %0d expected 0", nlp_tmr); end
        rst = 1'b0;
    endtask

    task automatic test_idle_nlp();
        logic [5:0] e;
        exp_q.delete();
        for (int c = 0; c < 3 * (P_NLP + 1); c++)
            exp_q.push_back((c % (P_NLP + 1) == P_NLP) ? E_NLP : E_WAIT);
        bus.link_en = 1'b1;
        tick();
        n_checks++;
        if (state !== ST_WAIT) begin n_fail++; $display("FAIL idle_enter_wait: got %0d expected %0d", state, ST_WAIT); end
        for (int k = 0; k < 3 * (P_NLP + 1); k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== e) begin n_fail++; $display("FAIL idle_nlp k=%0d: got %b expected %b", k, obs_vec(), e); end
            tick();
        end
        n_checks++;
        if (nlp_tmr !== '0) begin n_fail++; $display("FAIL idle_tmr_restart: got %0d expected 0", nlp_tmr); end
    endtask

    task automatic test_single_frame();
        logic [5:0] e;
        int gnt_k = -1000;
        repeat (10) tick();
        exp_q.delete();
        push_exp(1, E_WAIT); push_exp(1, E_GNT); push_exp(FLEN + 1, E_FRM);
        push_exp(P_IDL, E_IDL); push_exp(P_IPG, E_IPG); push_exp(1, E_WAIT);
        bus.frame_req = 1'b1;
        for (int k = 0; k < FLEN + P_IDL + P_IPG + 4; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== e) begin n_fail++; $display("FAIL single_frame k=%0d: got %b expected %b", k, obs_vec(), e); end
            if (k == FLEN + P_IDL + P_IPG + 3) begin
                n_checks++;
                if (nlp_tmr !== TW'(P_IPG)) begin n_fail++; $display("FAIL single_tmr_after_ipg: got %0d expected %0d", nlp_tmr, P_IPG); end
            end
            if (bus.frame_gnt) begin gnt_k = k; bus.frame_req = 1'b0; end
            bus.frame_active = (k >= gnt_k + 1) && (k <= gnt_k + FLEN);
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] e;
        logic [1:0] prev_sel = SEL_OFF;
        int gnt_k = -1000;
        int g1 = -1;
        int g2 = -1;
        int ipg1 = -1;
        exp_q.delete();
        for (int f = 0; f < 2; f++) begin
            push_exp(1, E_WAIT); push_exp(1, E_GNT); push_exp(FLEN + 1, E_FRM);
            push_exp(P_IDL, E_IDL); push_exp(P_IPG, E_IPG);
        end
        push_exp(1, E_WAIT);
        bus.frame_req = 1'b1;
        for (int k = 0; k < 2 * (FLEN + P_IDL + P_IPG + 3) + 1; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== e) begin n_fail++; $display("FAIL b2b k=%0d: got %b expected %b", k, obs_vec(), e); end
            if (k == FLEN + P_IDL + P_IPG + 3) begin
                n_checks++;
                if (nlp_tmr !== TW'(P_IPG)) begin n_fail++; $display("FAIL b2b_tmr_wait: got %0d expected %0d", nlp_tmr, P_IPG); end
            end
            if (ipg1 < 0 && prev_sel == SEL_IDL && bus.sel != SEL_IDL) ipg1 = k;
            prev_sel = bus.sel;
            if (bus.frame_gnt) begin
                gnt_k = k;
                if (g1 < 0) g1 = k;
                else begin
                    g2 = k;
                    bus.frame_req = 1'b0;
                    n_checks++;
                    if (nlp_tmr !== '0) begin n_fail++; $display("FAIL b2b_tmr_at_gnt2: got %0d expected 0", nlp_tmr); end
                end
            end
            bus.frame_active = (k >= gnt_k + 1) && (k <= gnt_k + FLEN);
            tick();
        end
        n_checks++;
        if (g2 - ipg1 !== 1 + P_IPG) begin n_fail++; $display("FAIL b2b_gap: got %0d expected %0d", g2 - ipg1, 1 + P_IPG); end
        n_checks++;
        if (g2 - g1 !== FLEN + P_IDL + P_IPG + 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d", g2 - g1, FLEN + P_IDL + P_IPG + 3); end
    endtask

    task automatic test_collision();
        logic [TW-1:0] due_val = TW'(P_NLP - 1);
        for (int i = 0; i < 2 * P_NLP && nlp_tmr !== due_val; i++) tick();
        n_checks++;
        if (nlp_tmr !== due_val || state !== ST_WAIT) begin
            n_fail++; $display("FAIL collision_reach_due: got tmr=%0d state=%0d expected tmr=%0d state=%0d", nlp_tmr, state, due_val, ST_WAIT);
        end
        bus.frame_req = 1'b1;
        tick();
        bus.frame_req = 1'b0;
        n_checks++;
        if ({bus.frame_gnt, bus.nlp_go, bus.sel} !== {1'b1, 1'b0, SEL_FRAME}) begin
            n_fail++; $display("FAIL collision_gnt: got gnt=%b go=%b sel=%b expected gnt=1 go=0 sel=10", bus.frame_gnt, bus.nlp_go, bus.sel);
        end
        n_checks++;
        if (nlp_tmr !== '0) begin n_fail++; $display("FAIL collision_tmr: got %0d expected 0", nlp_tmr); end
    endtask

    task automatic test_start_timeout();
        logic [5:0] e;
        exp_q.delete();
        push_exp(1, E_GNT); push_exp(P_START - 1, E_FRM); push_exp(P_IPG, E_IPG); push_exp(1, E_WAIT);
        for (int k = 0; k < P_START + P_IPG + 1; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== e) begin n_fail++; $display("FAIL start_timeout k=%0d: got %b expected %b", k, obs_vec(), e); end
            if (k == P_START) begin
                n_checks++;
                if (state !== ST_IPG) begin n_fail++; $display("FAIL timeout_state: got %0d expected %0d", state, ST_IPG); end
            end
            tick();
        end
    endtask

    task automatic test_jabber();
        logic [5:0] e;
        int gnt_k = -1000;
        int quiet = 0;
        exp_q.delete();
        push_exp(1, E_WAIT); push_exp(1, E_GNT); push_exp(P_JAB, E_FRM);
        push_exp(5 + P_UNJAB, E_JAB); push_exp(1, E_WAIT);
        bus.frame_req = 1'b1;
        for (int k = 0; k < P_JAB + P_UNJAB + 8; k++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_vec() !== e) begin n_fail++; $display("FAIL jabber k=%0d: got %b expected %b", k, obs_vec(), e); end
            if (bus.frame_gnt) begin gnt_k = k; bus.frame_req = 1'b0; end
            bus.frame_active = (k >= gnt_k + 1) && (k <= gnt_k + P_JAB + 5);
            bus.link_en = !(k >= 38 && k <= 40);
            if (bus.jabber && !bus.frame_active) quiet++;
            tick();
        end
        n_checks++;
        if (quiet !== P_UNJAB) begin n_fail++; $display("FAIL unjab_quiet: got %0d expected %0d", quiet, P_UNJAB); end
    endtask

    task automatic test_link_drop();
        bus.frame_req = 1'b1;
        tick();
        bus.frame_req = 1'b0;
        n_checks++;
        if (bus.frame_gnt !== 1'b1) begin n_fail++; $display("FAIL link_drop_gnt: got %b expected 1", bus.frame_gnt); end
        bus.frame_active = 1'b1;
        tick();
        bus.link_en = 1'b0;
        tick();
        n_checks++;
        if ({state, obs_vec()} !== {ST_OFF, E_WAIT}) begin
            n_fail++; $display("FAIL link_drop_off: got state=%0d out=%b expected state=%0d out=%b", state, obs_vec(), ST_OFF, E_WAIT);
        end
        bus.frame_active = 1'b0;
        bus.link_en = 1'b1;
        tick();
        n_checks++;
        if (state !== ST_WAIT) begin n_fail++; $display("FAIL link_restore: got %0d expected %0d", state, ST_WAIT); end
    endtask

    task automatic test_reset_mid_frame();
        bus.frame_req = 1'b1;
        tick();
        bus.frame_req = 1'b0;
        bus.frame_active = 1'b1;
        tick();
        tick();
        n_checks++;
        if (state !== ST_FRAME) begin n_fail++; $display("FAIL mid_frame_state: got %0d expected %0d", state, ST_FRAME); end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({state, obs_vec()} !== {ST_OFF, E_WAIT}) begin
            n_fail++; $display("FAIL reset_mid_frame: got state=%0d out=%b expected state=%0d out=%b", state, obs_vec(), ST_OFF, E_WAIT);
        end
        n_checks++;
        if (nlp_tmr !== '0) begin n_fail++; $display("FAIL reset_mid_tmr: got %0d expected 0", nlp_tmr); end
        rst = 1'b0;
        bus.frame_active = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_idle_nlp();
        test_single_frame();
        test_back_to_back();
        test_collision();
        test_start_timeout();
        test_jabber();
        test_link_drop();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_tx_sched.md
Name: eth_tx_sched

Overview:
- Transmit scheduler for the 10BASE-T TX path; one clk cycle = one bit time (100 ns at 10 MHz).
- Decides which source drives the twisted-pair line driver: normal link pulses (NLP), frame data, TP_IDL end-of-frame hold, or silence.
- Grants frame starts to the frame engine and enforces TP_IDL and the inter-packet gap (IPG).
- Suppresses NLPs during traffic and applies jabber protection.
- Sits between the MAC-side request logic and the NLP/frame generators plus the output mux.

Parameters:
- NLP_PERIOD, 160000, cycles of line silence between NLPs (16 ms).
- NLP_WIDTH, 1, cycles the NLP source is selected (100 ns pulse).
- IDL_CYCLES, 3, cycles of TP_IDL high hold after the last frame bit (300 ns).
- IPG_CYCLES, 96, inter-packet gap in bit times.
- START_TO, 16, max cycles from frame_gnt to frame_active rising.
- JABBER_CYCLES, 200000, max continuous frame_active (20 ms).
- UNJAB_CYCLES, 5000, quiet cycles after frame_active falls before leaving jabber.

Ports:
- clk, in, 1, 10 MHz bit clock.
- rst, in, 1, synchronous active-high reset.
- link_en, in, 1, enables all transmit activity; 0 forces line silent.
- frame_req, in, 1, level request from MAC side; held until frame_gnt.
- frame_gnt, out, 1, one-cycle pulse: frame engine may start.
- frame_active, in, 1, high while the frame engine emits Manchester bits.
- nlp_go, out, 1, one-cycle pulse to the NLP generator.
- sel, out, 2, line source: 00 silent, 01 NLP, 10 frame, 11 TP_IDL (drives Txp high, Txn low).
- busy, out, 1, high in any state other than WAIT or OFF.
- jabber, out, 1, high while in JABBER.

Behaviour:
- Reset values: state=OFF, all counters 0, frame_gnt=0, nlp_go=0, sel=00, busy=0, jabber=0. Reset mid-frame aborts immediately, with the same values.
- Counters:
  - One state counter (cnt) is cleared on every state entry.
  - nlp_tmr is separate and counts only in WAIT and IPG; it is cleared in all other states.
  - Widths are clog2 of the largest parameter plus 1.
- OFF: sel=00. Go to WAIT when link_en=1.
- link_en=0 in any state except JABBER forces OFF on the next cycle. A frame abort is flagged by frame_gnt staying 0 and sel=00.
- WAIT: sel=00. Priority order:
  - frame_req=1 -> FRAME, frame_gnt=1 in the entry cycle, nlp_tmr cleared. A frame wins over a simultaneously due NLP.
  - Otherwise, nlp_tmr == NLP_PERIOD-1 -> NLP, nlp_go=1 in the entry cycle.
- NLP: sel=01 for NLP_WIDTH cycles -> WAIT, with nlp_tmr restarting from 0. frame_req arriving in NLP waits until WAIT.
- FRAME: sel=10.
  - frame_active falls (1->0) -> TP_IDL.
  - frame_active not seen high within START_TO cycles of entry -> IPG (timeout, no TP_IDL).
  - frame_active continuously high for JABBER_CYCLES -> JABBER.
- TP_IDL: sel=11 for IDL_CYCLES cycles -> IPG.
- IPG: sel=00 for IPG_CYCLES cycles -> WAIT.
  - frame_req held through IPG is granted on the first WAIT cycle, i.e. 1 + IPG_CYCLES cycles after TP_IDL ends.
  - nlp_tmr reaching expiry inside IPG is held at NLP_PERIOD-1 and serviced in WAIT.
- JABBER: sel=00, jabber=1, frame_gnt suppressed.
  - cnt counts only while frame_active=0 and restarts on any frame_active=1.
  - cnt reaching UNJAB_CYCLES -> WAIT, jabber=0.
  - link_en is ignored in JABBER.
- Timing rules:
  - Back-to-back grants are spaced by at least frame length + IDL_CYCLES + IPG_CYCLES + 1 cycles.
  - sel changes only on state transitions.
  - nlp_go and frame_gnt are never high in the same cycle.

Decomposition:
- Shared package eth_tx_pkg holds:
  - state enum: OFF, WAIT, NLP, FRAME, TP_IDL, IPG, JABBER;
  - sel encodings: SEL_OFF, SEL_NLP, SEL_FRAME, SEL_IDL;
  - default timing constants.
- One sub-module is natural: eth_nlp_timer, which owns nlp_tmr with count/clear/hold inputs and a due output.
- The FSM and counters stay in eth_tx_sched.

Test Plan:
Simulation overrides: NLP_PERIOD=50, IPG_CYCLES=8, IDL_CYCLES=3, START_TO=4, JABBER_CYCLES=30, UNJAB_CYCLES=10.
- Idle link: rst 2 cycles, then link_en=1, no frame_req -> nlp_go pulses every 51 cycles (1 WAIT→NLP cycle + 50), sel=01 for exactly 1 cycle each time.
- Single frame: frame_req at cycle 10, frame_active high for 20 cycles starting 2 cycles after frame_gnt -> sel sequence 10(22) 11(3) 00(8), then WAIT; no nlp_go during that time.
- Back-to-back: frame_req held high across two frames -> second frame_gnt exactly 9 cycles after TP_IDL ends; nlp_tmr restarts after each frame.
- Collision of events: frame_req rises in the cycle nlp_tmr hits 49 -> frame_gnt=1, nlp_go=0, nlp_tmr=0 next cycle.
- Start timeout: frame_gnt issued, frame_active stays 0 -> IPG after 4 cycles, sel never 11.
- Jabber and reset: frame_active stuck high 30 cycles -> jabber=1, sel=00; drop frame_active -> jabber=0 after 10 cycles. Separately, rst asserted mid-FRAME -> next cycle sel=00, busy=0, state OFF.
